// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with IF/ID pipeline register.
//
// Issues word-aligned requests to instruction memory over a req/ready
// handshake and presents fetched instructions on the IF/ID register.
// One returning instruction can be parked in a skid buffer while decode
// stalls. A redirect squashes the current fetch. If a request is still
// outstanding, its response is discarded in the DROP state.
//
// Optional feature: define FETCH_PERF_CNT_EN to build the bubble counter.
// Without it, fetch_bubbles is tied to zero.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   imem_req, imem_addr    fetch request / word address (out)
//   imem_ready, imem_rdata response strobe / instruction (in)
//   stall                  decode cannot accept; IF/ID holds
//   redirect, redirect_pc  taken branch/jump pulse and target
//   ifid_valid, ifid_pc, ifid_pc_plus4, ifid_instr   IF/ID register
//   fetch_bubbles          count of bubble cycles (optional)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | reset state; moves to FETCH on the next edge
// FETCH | request outstanding to pc_q
// SKID  | one instruction buffered for stalled decode; no request
// DROP  | request outstanding whose response will be discarded
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  ifid_valid,
  output logic [DATA_WIDTH-1:0] ifid_pc,
  output logic [DATA_WIDTH-1:0] ifid_pc_plus4,
  output logic [DATA_WIDTH-1:0] ifid_instr,
  output logic [31:0]           fetch_bubbles
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SKID  = 2'd2,
    S_DROP  = 2'd3
  } state_t;

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] drop_addr_q, drop_addr_d;
  logic [DATA_WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic [DATA_WIDTH-1:0] skid_instr_q, skid_instr_d;
  logic                  ifid_valid_d;
  logic [DATA_WIDTH-1:0] ifid_pc_d, ifid_pc_plus4_d, ifid_instr_d;
  logic [DATA_WIDTH-1:0] redirect_target;

  // The low target bits are forced to zero, so they are never read.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign redirect_target      = {redirect_pc[DATA_WIDTH-1:2], 2'b00};

  // DROP keeps presenting the abandoned address, so the memory sees a
  // stable request even though pc_q already points at the new target.
  assign imem_req  = (state_q == S_FETCH) || (state_q == S_DROP);
  assign imem_addr = (state_q == S_DROP) ? drop_addr_q : pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      drop_addr_q   <= RESET_PC;
      skid_pc_q     <= '0;
      skid_instr_q  <= '0;
      ifid_valid    <= 1'b0;
      ifid_pc       <= '0;
      ifid_pc_plus4 <= '0;
      ifid_instr    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drop_addr_q   <= drop_addr_d;
      skid_pc_q     <= skid_pc_d;
      skid_instr_q  <= skid_instr_d;
      ifid_valid    <= ifid_valid_d;
      ifid_pc       <= ifid_pc_d;
      ifid_pc_plus4 <= ifid_pc_plus4_d;
      ifid_instr    <= ifid_instr_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    drop_addr_d     = drop_addr_q;
    skid_pc_d       = skid_pc_q;
    skid_instr_d    = skid_instr_q;
    ifid_valid_d    = ifid_valid;
    ifid_pc_d       = ifid_pc;
    ifid_pc_plus4_d = ifid_pc_plus4;
    ifid_instr_d    = ifid_instr;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ready) begin
          pc_d = pc_q + PC_STEP;
          if (stall) begin
            skid_pc_d    = pc_q;
            skid_instr_d = imem_rdata;
            state_d      = S_SKID;
          end else begin
            ifid_valid_d    = 1'b1;
            ifid_pc_d       = pc_q;
            ifid_pc_plus4_d = pc_q + PC_STEP;
            ifid_instr_d    = imem_rdata;
          end
        end else if (!stall) begin
          ifid_valid_d = 1'b0;
        end
      end
      S_SKID: begin
        if (!stall) begin
          ifid_valid_d    = 1'b1;
          ifid_pc_d       = skid_pc_q;
          ifid_pc_plus4_d = skid_pc_q + PC_STEP;
          ifid_instr_d    = skid_instr_q;
          state_d         = S_FETCH;
        end
      end
      S_DROP: begin
        if (imem_ready) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase

    // Redirect overrides everything above. An unanswered request must
    // still be drained. A redirect that arrives while draining keeps
    // waiting, unless the drained response lands in the same cycle.
    if (redirect) begin
      pc_d         = redirect_target;
      ifid_valid_d = 1'b0;
      skid_pc_d    = '0;
      skid_instr_d = '0;
      if ((state_q == S_FETCH || state_q == S_DROP) && !imem_ready) begin
        state_d = S_DROP;
        if (state_q == S_FETCH) drop_addr_d = pc_q;
      end else begin
        state_d = S_FETCH;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] bubbles_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       bubbles_q <= '0;
    else if (!stall && !ifid_valid_d) bubbles_q <= bubbles_q + 32'd1;
  end

  assign fetch_bubbles = bubbles_q;
`else
  assign fetch_bubbles = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic [31:0] ifid_instr;
  logic [31:0] fetch_bubbles;

  fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .ifid_valid(ifid_valid), .ifid_pc(ifid_pc),
    .ifid_pc_plus4(ifid_pc_plus4), .ifid_instr(ifid_instr),
    .fetch_bubbles(fetch_bubbles)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // memory model knobs and state
  int lat_lo, lat_hi, p_stall, p_redir;
  bit mbusy;
  int mwait;

  // reference model: mode 0 idle, 1 fetching, 2 holding a skid entry, 3 draining
  int          m_mode;
  logic [31:0] m_pc, m_drop_addr, m_skid_pc, m_skid_ins;
  logic [31:0] m_ipc, m_ip4, m_ins, m_bub;
  bit          m_v;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = 32'h0; m_drop_addr = 32'h0;
    m_skid_pc = 0; m_skid_ins = 0;
    m_v = 0; m_ipc = 0; m_ip4 = 0; m_ins = 0; m_bub = 0;
  endtask

  task automatic model_edge(input bit st, input bit rd, input logic [31:0] rpc,
                            input bit rdy, input logic [31:0] rdat);
    bit          deliver;
    logic [31:0] dpc, dins;
    int          nxt;
    deliver = 0; dpc = 0; dins = 0; nxt = m_mode;
    if (m_mode == 0) nxt = 1;
    else if (m_mode == 1 && rdy) begin
      if (st) begin m_skid_pc = m_pc; m_skid_ins = rdat; nxt = 2; end
      else    begin deliver = 1; dpc = m_pc; dins = rdat; end
      m_pc = m_pc + 32'd4;
    end else if (m_mode == 2 && !st) begin
      deliver = 1; dpc = m_skid_pc; dins = m_skid_ins; nxt = 1;
    end else if (m_mode == 3 && rdy) nxt = 1;

    if (deliver) begin m_v = 1; m_ipc = dpc; m_ip4 = dpc + 32'd4; m_ins = dins; end
    else if (!st) m_v = 0;

    if (rd) begin
      if (m_mode == 1 && !rdy) m_drop_addr = m_pc;
      nxt  = ((m_mode == 1 || m_mode == 3) && !rdy) ? 3 : 1;
      m_pc = rpc & 32'hFFFF_FFFC;
      m_v  = 0;
    end
    m_mode = nxt;
`ifdef FETCH_PERF_CNT_EN
    if (!st && !m_v) m_bub = m_bub + 32'd1;
`endif
  endtask

  task automatic check_all();
    chk("imem_req", {31'b0, imem_req}, {31'b0, (m_mode == 1 || m_mode == 3)});
    chk("imem_addr", imem_addr, (m_mode == 3) ? m_drop_addr : m_pc);
    chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_v});
    chk("ifid_pc", ifid_pc, m_ipc);
    chk("ifid_pc_plus4", ifid_pc_plus4, m_ip4);
    chk("ifid_instr", ifid_instr, m_ins);
    chk("fetch_bubbles", fetch_bubbles, m_bub);
    if (m_v) chk("instr_word", ifid_instr, mem_word(m_ipc));
  endtask

  task automatic step(input bit st, input bit rd, input logic [31:0] rpc);
    stall = st; redirect = rd; redirect_pc = rpc;
    if (imem_req && !mbusy) begin
      mbusy = 1;
      mwait = $urandom_range(lat_hi, lat_lo);
    end
    imem_ready = mbusy && (mwait == 0);
    imem_rdata = imem_ready ? mem_word(imem_addr) : $urandom;
    @(posedge clk);
    model_edge(st, rd, rpc, imem_ready, imem_rdata);
    if (mbusy) begin
      if (imem_ready) mbusy = 0;
      else mwait--;
    end
    #1;
    check_all();
  endtask

  task automatic step_rand();
    bit          st, rd;
    logic [31:0] rpc;
    st  = ($urandom_range(99, 0) < p_stall);
    rd  = ($urandom_range(99, 0) < p_redir);
    rpc = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFFC : $urandom;
    step(st, rd, rpc);
  endtask

  initial begin
    rst_n = 0; stall = 0; redirect = 0; redirect_pc = 0;
    imem_ready = 0; imem_rdata = 0; mbusy = 0; mwait = 0;
    lat_lo = 0; lat_hi = 0; p_stall = 0; p_redir = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_req", {31'b0, imem_req}, 32'h0);
    chk("reset_addr", imem_addr, 32'h0);
    chk("reset_plus4", ifid_pc_plus4, 32'h0);
    rst_n = 1;

    // zero-wait memory, no stall
    step(0, 0, 0);
    chk("first_req", {31'b0, imem_req}, 32'h1);
    chk("first_valid", {31'b0, ifid_valid}, 32'h0);
    step(0, 0, 0); chk("seq_pc0", ifid_pc, 32'h0);
    chk("seq_valid", {31'b0, ifid_valid}, 32'h1);
    step(0, 0, 0); chk("seq_pc4", ifid_pc, 32'h4);
    step(0, 0, 0); chk("seq_pc8", ifid_pc, 32'h8);
    step(0, 0, 0); chk("seq_pcC", ifid_pc, 32'hC);

    // two-cycle latency
    lat_lo = 2; lat_hi = 2;
    repeat (9) step(0, 0, 0);

    // stall while a response returns
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 6 && m_mode != 2; i++) step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    chk("skid_req_low", {31'b0, imem_req}, 32'h0);
    repeat (6) step(0, 0, 0);

    // redirect while a request to 0x10 is pending
    lat_lo = 3; lat_hi = 3;
    step(0, 1, 32'h10);
    for (int i = 0; i < 10 && !(m_mode == 1 && m_pc == 32'h10); i++) step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 32'h0000_0102);
    chk("drop_addr_held", imem_addr, 32'h10);
    chk("drop_req", {31'b0, imem_req}, 32'h1);
    chk("drop_valid", {31'b0, ifid_valid}, 32'h0);
    for (int i = 0; i < 20 && !ifid_valid; i++) step(0, 0, 0);
    chk("redir_valid", {31'b0, ifid_valid}, 32'h1);
    chk("redir_pc", ifid_pc, 32'h100);
    chk("redir_instr", ifid_instr, mem_word(32'h100));

    // redirect to the top word: PC wraps to zero
    lat_lo = 0; lat_hi = 0;
    step(0, 1, 32'hFFFF_FFFE);
    for (int i = 0; i < 20 && !ifid_valid; i++) step(0, 0, 0);
    chk("wrap_pc", ifid_pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", ifid_pc_plus4, 32'h0);
    chk("wrap_next_addr", imem_addr, 32'h0);
    step(0, 0, 0);
    chk("wrap_next_pc", ifid_pc, 32'h0);

    // randomized traffic
    lat_lo = 0; lat_hi = 3; p_stall = 30; p_redir = 8;
    repeat (3000) step_rand();
    lat_lo = 0; lat_hi = 0; p_stall = 50; p_redir = 15;
    repeat (1000) step_rand();

    // asynchronous reset mid-run
    rst_n = 0; stall = 0; redirect = 0; imem_ready = 0; mbusy = 0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1;
    lat_lo = 0; lat_hi = 2; p_stall = 20; p_redir = 5;
    repeat (200) step_rand();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
